queue_rd_pipe: RTL and testbench

//  Read-side drain engine for a queue_cntrl + synchronous-RAM queue. Pops the

---
 rtl/queue_rd_pipe.sv | 101 ++++++++++
 tb/tb_queue_rd_pipe.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/queue_rd_pipe.sv
// rtl/queue_rd_pipe.sv - queue read drain engine: credit-managed pop, RAM latency staging, valid/ready output
// Optional entry parity checking is enabled by defining Q_RD_PIPE_PARITY_EN.
`timescale 1ns/1ps

module queue_rd_pipe #(
  parameter int W       = 32,
  parameter int RAM_LAT = 1
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         i_empty,
  output logic         o_pop,
`ifdef Q_RD_PIPE_PARITY_EN
  input  logic [W:0]   i_rdata,
`else
  input  logic [W-1:0] i_rdata,
`endif
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_ready,
  output logic         o_busy
`ifdef Q_RD_PIPE_PARITY_EN
  ,
  output logic         o_perr
`endif
);

  localparam int D  = RAM_LAT + 2;
  localparam int CW = $clog2(D + 1);
  localparam int PW = $clog2(D);

  logic [RAM_LAT-1:0] infl_sr;
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      occ_r;
  logic [CW:0]        credit_used;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [W-1:0]       stage_q [D];
  logic               arrive;
  logic               deq;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RAM_LAT; i++) begin
      inflight = inflight + CW'(infl_sr[i]);
    end
  end

  // Credit uses registered counts only, so i_ready never reaches o_pop combinationally.
  assign credit_used = {1'b0, occ_r} + {1'b0, inflight};
  assign o_pop       = arst_n & ~i_empty & (credit_used < (CW + 1)'(D));

  assign arrive  = infl_sr[RAM_LAT-1];
  assign o_valid = (occ_r != '0);
  assign deq     = o_valid & i_ready;
  assign o_data  = stage_q[rd_ptr];
  assign o_busy  = (inflight != '0) | (occ_r != '0);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      infl_sr <= '0;
      occ_r   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      infl_sr <= (infl_sr << 1) | RAM_LAT'(o_pop);
      occ_r   <= occ_r + CW'(arrive) - CW'(deq);
      if (arrive) wr_ptr <= next_ptr(wr_ptr);
      if (deq)    rd_ptr <= next_ptr(rd_ptr);
    end
  end

  // Storage is cleared so o_data reads zero out of reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < D; i++) stage_q[i] <= '0;
    end else if (arrive) begin
      stage_q[wr_ptr] <= i_rdata[W-1:0];
    end
  end

`ifdef Q_RD_PIPE_PARITY_EN
  logic [D-1:0] perr_q;

  // Even parity over data plus parity bit: any odd total marks the entry bad.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      perr_q <= '0;
    end else if (arrive) begin
      perr_q[wr_ptr] <= ^i_rdata;
    end
  end

  assign o_perr = o_valid & perr_q[rd_ptr];
`endif

endmodule

// File: tb/tb_queue_rd_pipe.sv
// tb/tb_queue_rd_pipe.sv - directed bench for queue_rd_pipe at RAM_LAT=2 (u0) and RAM_LAT=1 (u1)
`timescale 1ns/1ps

module tb_queue_rd_pipe;
  localparam int W = 32;
`ifdef Q_RD_PIPE_PARITY_EN
  localparam int RW = W + 1;
`else
  localparam int RW = W;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst_n;
  logic [1:0]    e, pop, vld, rdy, busy;
  logic [RW-1:0] rd [2];
  logic [W-1:0]  od [2];
`ifdef Q_RD_PIPE_PARITY_EN
  logic [1:0]    perr;
  int            perr_hits;
`endif

  queue_rd_pipe #(.W(W), .RAM_LAT(2)) u0 (
    .clk(clk), .arst_n(arst_n), .i_empty(e[0]), .o_pop(pop[0]), .i_rdata(rd[0]),
    .o_valid(vld[0]), .o_data(od[0]), .i_ready(rdy[0]), .o_busy(busy[0])
`ifdef Q_RD_PIPE_PARITY_EN
    , .o_perr(perr[0])
`endif
  );

  queue_rd_pipe #(.W(W), .RAM_LAT(1)) u1 (
    .clk(clk), .arst_n(arst_n), .i_empty(e[1]), .o_pop(pop[1]), .i_rdata(rd[1]),
    .o_valid(vld[1]), .o_data(od[1]), .i_ready(rdy[1]), .o_busy(busy[1])
`ifdef Q_RD_PIPE_PARITY_EN
    , .o_perr(perr[1])
`endif
  );

  // Queue + RAM model: entries leave in push order; i_rdata follows o_pop by RAM_LAT.
  logic [RW-1:0] src_mem [2][128];
  int            head [2];
  int            tail [2];
  int            acc [2];
  int            max_out [2];
  logic [RW-1:0] pd_d [2][4];
  bit            prev_stall [2];
  logic [W-1:0]  prev_data [2];
  bit            last_pop, last_vld;
  logic [W-1:0]  last_data;
  int            n_cmp = 0;
  int            n_err = 0;

  typedef struct {
    int           s;
    logic [W-1:0] data;
    int           exp_lat;
  } vec_t;
  vec_t tbl [4];

  function automatic int lat(input int s);
    return (s == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_raw(input int s, input logic [RW-1:0] d);
    src_mem[s][tail[s]] = d;
    tail[s]++;
  endtask

  task automatic push(input int s, input logic [W-1:0] d);
`ifdef Q_RD_PIPE_PARITY_EN
    push_raw(s, {^d, d});
`else
    push_raw(s, d);
`endif
  endtask

  task automatic model_clear(input int s);
    head[s] = tail[s];
    acc[s]  = tail[s];
    prev_stall[s] = 1'b0;
    for (int k = 0; k < 4; k++) pd_d[s][k] = '0;
  endtask

  task automatic cyc(input int s, input bit r);
    logic [RW-1:0] nd;
    int ob;
    @(negedge clk);
    rdy[s] = r;
    e[s]   = (head[s] == tail[s]);
    rd[s]  = pd_d[s][lat(s)-1];
    #1;
    last_pop  = pop[s];
    last_vld  = vld[s];
    last_data = od[s];
    if (prev_stall[s]) begin
      chk("hold_valid", vld[s], 1);
      chk("hold_data", od[s], prev_data[s]);
    end
    ob = head[s] - acc[s];
    if (ob > max_out[s]) max_out[s] = ob;
`ifdef Q_RD_PIPE_PARITY_EN
    if (perr[s]) perr_hits++;
    if (vld[s] && acc[s] < head[s]) chk("perr", perr[s], ^src_mem[s][acc[s]]);
    else chk("perr_idle", perr[s], 0);
`endif
    if (vld[s] && r) begin
      if (acc[s] >= head[s]) chk("spurious_valid", 1, 0);
      else begin
        chk("order", od[s], src_mem[s][acc[s]][W-1:0]);
        acc[s]++;
      end
    end
    prev_stall[s] = vld[s] && !r;
    prev_data[s]  = od[s];
    nd = '0;
    if (pop[s]) begin
      if (head[s] < tail[s]) begin
        nd = src_mem[s][head[s]];
        head[s]++;
      end else chk("pop_when_empty", 1, 0);
    end
    @(posedge clk);
    #1;
    for (int k = 3; k > 0; k--) pd_d[s][k] = pd_d[s][k-1];
    pd_d[s][0] = nd;
    e[s]   = (head[s] == tail[s]);
    rdy[s] = 1'b0;
  endtask

  task automatic drain(input int s, input string name);
    int n;
    n = 0;
    while (acc[s] != tail[s] && n < 40) begin
      cyc(s, 1'b1);
      n++;
    end
    cyc(s, 1'b1);
    chk({name, "_all_delivered"}, acc[s], tail[s]);
    chk({name, "_idle"}, busy[s], 0);
  endtask

  initial begin
    int k, npop, pf, pl, pc, af, al, ac;

    tbl[0] = '{s: 0, data: 32'hA5A5_0001, exp_lat: 3};
    tbl[1] = '{s: 0, data: 32'hDEAD_BEEF, exp_lat: 3};
    tbl[2] = '{s: 1, data: 32'h1234_5678, exp_lat: 2};
    tbl[3] = '{s: 1, data: 32'h0000_0000, exp_lat: 2};

    for (int s = 0; s < 2; s++) begin
      head[s] = 0; tail[s] = 0; max_out[s] = 0;
      model_clear(s);
      rd[s] = '0;
    end
`ifdef Q_RD_PIPE_PARITY_EN
    perr_hits = 0;
`endif

    // Reset state, with i_empty low to show o_pop is held off during reset
    arst_n = 1'b0;
    e      = 2'b00;
    rdy    = 2'b00;
    #12;
    chk("rst_pop0", pop[0], 0);
    chk("rst_pop1", pop[1], 0);
    chk("rst_valid", vld, 0);
    chk("rst_data", od[0], 0);
    chk("rst_busy", busy, 0);
    e = 2'b11;
    @(negedge clk);
    arst_n = 1'b1;

    // Single-entry latency vectors
    for (int i = 0; i < 4; i++) begin
      push(tbl[i].s, tbl[i].data);
      cyc(tbl[i].s, 1'b1);
      chk("tbl_pop", last_pop, 1);
      k = 0;
      do begin
        cyc(tbl[i].s, 1'b1);
        k++;
      end while (!last_vld && k < 8);
      chk("tbl_latency", k, tbl[i].exp_lat);
      chk("tbl_data", last_data, tbl[i].data);
      cyc(tbl[i].s, 1'b1);
      chk("tbl_idle", busy[tbl[i].s], 0);
    end

    // Asynchronous reset with three entries staged
    for (int i = 0; i < 5; i++) push(0, 32'h5000 + i);
    for (int i = 0; i < 5; i++) cyc(0, 1'b0);
    chk("t1_staged_valid", vld[0], 1);
    chk("t1_staged_head", od[0], 32'h5000);
    @(negedge clk);
    #2 arst_n = 1'b0;
    #1;
    chk("t1_async_valid", vld[0], 0);
    chk("t1_async_pop", pop[0], 0);
    chk("t1_async_busy", busy[0], 0);
    model_clear(0);
    e[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1'b1);
      chk("t1_post_pop", last_pop, 0);
      chk("t1_post_valid", last_vld, 0);
    end

    // Full throughput, RAM_LAT=2
    for (int i = 0; i < 16; i++) push(0, i);
    pf = -1; pl = -1; pc = 0; af = -1; al = -1; ac = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(0, 1'b1);
      if (last_pop) begin
        if (pf < 0) pf = i;
        pl = i;
        pc++;
      end
      if (last_vld) begin
        if (af < 0) af = i;
        al = i;
        ac++;
      end
    end
    chk("t3_pop_count", pc, 16);
    chk("t3_pop_span", pl - pf + 1, 16);
    chk("t3_acc_count", ac, 16);
    chk("t3_acc_span", al - af + 1, 16);
    chk("t3_first_acc", af - pf, 3);

    // Backpressure: exactly D=4 pops then stop
    for (int i = 0; i < 8; i++) push(0, 32'hB000 + i);
    npop = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1'b0);
      if (last_pop) npop++;
    end
    chk("t4_pops_under_stall", npop, 4);
    chk("t4_pop_stopped", last_pop, 0);
    cyc(0, 1'b1);
    cyc(0, 1'b1);
    chk("t4_pop_resumed", last_pop, 1);
    drain(0, "t4");

    // Wrap with RAM_LAT=1 (D=3) and random ready
    max_out[1] = 0;
    for (int i = 0; i < 10; i++) push(1, 32'hC000 + i);
    for (int i = 0; i < 60; i++) cyc(1, 1'($urandom_range(0, 1)));
    drain(1, "t5");
    chk("t5_occ_le_3", max_out[1] <= 3, 1);

`ifdef Q_RD_PIPE_PARITY_EN
    perr_hits = 0;
    push_raw(0, {1'b0, 32'h1});
    push_raw(0, {1'b0, 32'h3});
    drain(0, "t6");
    chk("t6_perr_hits", perr_hits, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
